// File: rtl/residual_adder_pipe_if.sv
// Beat-level handshake bundle for residual_adder_pipe: operand input channel and result channel.
interface residual_adder_pipe_if #(
    parameter int LANES  = 16,
    parameter int IN_W   = 8,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 12
);
    logic                   in_vld;
    logic                   in_rdy;
    logic [LANES*IN_W-1:0]  in_a;
    logic [LANES*IN_W-1:0]  in_b;
    logic [ADDR_W-1:0]      in_addr;
    logic                   in_last;
    logic                   out_vld;
    logic                   out_rdy;
    logic [LANES*OUT_W-1:0] out_data;
    logic [ADDR_W-1:0]      out_addr;
    logic                   out_last;

    // master is the surrounding environment (SRAM read path + write-back), slave is the adder
    modport master (output in_vld, in_a, in_b, in_addr, in_last, out_rdy,
                    input  in_rdy, out_vld, out_data, out_addr, out_last);
    modport slave  (input  in_vld, in_a, in_b, in_addr, in_last, out_rdy,
                    output in_rdy, out_vld, out_data, out_addr, out_last);
endinterface

// File: rtl/residual_adder_pipe.sv
// Multi-lane residual adder: dequantise, combine, round-shift, saturate, with sideband carried along.
// Optional clipped-lane statistics counter enabled by defining RESADD_SAT_STAT_EN.
module residual_adder_pipe #(
    parameter int LANES     = 16,
    parameter int IN_W      = 8,
    parameter int OUT_W     = 8,
    parameter int SCALE_W   = 16,
    parameter int SHIFT_W   = 5,
    parameter int ADDR_W    = 12,
    parameter int RT_STAGES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_vld,
    input  logic [SCALE_W-1:0]   cfg_scale_a,
    input  logic [SCALE_W-1:0]   cfg_scale_b,
    input  logic [SHIFT_W-1:0]   cfg_shift,
    input  logic [1:0]           cfg_mode,
    output logic                 cfg_err,
    residual_adder_pipe_if.slave bus,
    output logic                 busy
`ifdef RESADD_SAT_STAT_EN
    ,
    output logic [15:0]          sat_cnt
`endif
);
    localparam int PROD_W = IN_W + SCALE_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int T      = RT_STAGES;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    logic adv, cfg_load;
    logic [SCALE_W-1:0] scale_a_q, scale_b_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [1:0]         mode_q;

    assign adv        = ~bus.out_vld | bus.out_rdy;
    assign bus.in_rdy = adv;
    assign cfg_load   = cfg_vld & ~busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_a_q <= '0;
            scale_b_q <= '0;
            shift_q   <= '0;
            mode_q    <= '0;
            cfg_err   <= 1'b0;
        end else begin
            if (cfg_load) begin
                scale_a_q <= cfg_scale_a;
                scale_b_q <= cfg_scale_b;
                shift_q   <= cfg_shift;
                mode_q    <= cfg_mode;
            end
            if (cfg_vld && busy) cfg_err <= 1'b1;
        end
    end

    // Each beat snapshots the config at acceptance, so a same-cycle config write cannot affect it
    logic                      s0_vld, s0_last;
    logic [ADDR_W-1:0]         s0_addr;
    logic signed [IN_W-1:0]    s0_a [LANES];
    logic signed [IN_W-1:0]    s0_b [LANES];
    logic [SCALE_W-1:0]        s0_scale_a, s0_scale_b;
    logic [SHIFT_W-1:0]        s0_shift;
    logic [1:0]                s0_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld <= 1'b0; s0_last <= 1'b0; s0_addr <= '0;
            s0_scale_a <= '0; s0_scale_b <= '0; s0_shift <= '0; s0_mode <= '0;
            for (int i = 0; i < LANES; i++) begin
                s0_a[i] <= '0;
                s0_b[i] <= '0;
            end
        end else if (adv) begin
            s0_vld <= bus.in_vld; s0_last <= bus.in_last; s0_addr <= bus.in_addr;
            s0_scale_a <= scale_a_q; s0_scale_b <= scale_b_q;
            s0_shift <= shift_q; s0_mode <= mode_q;
            for (int i = 0; i < LANES; i++) begin
                s0_a[i] <= bus.in_a[i*IN_W +: IN_W];
                s0_b[i] <= bus.in_b[i*IN_W +: IN_W];
            end
        end
    end

    logic signed [PROD_W-1:0] prod_a [LANES];
    logic signed [PROD_W-1:0] prod_b [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_a[i] = $signed(PROD_W'(s0_a[i])) * $signed(PROD_W'(s0_scale_a));
            prod_b[i] = $signed(PROD_W'(s0_b[i])) * $signed(PROD_W'(s0_scale_b));
        end
    end

    // Index 0 is the multiplier register; indices 1..RT_STAGES are plain retiming copies
    logic                     m_vld   [RT_STAGES+1];
    logic                     m_last  [RT_STAGES+1];
    logic [ADDR_W-1:0]        m_addr  [RT_STAGES+1];
    logic [SHIFT_W-1:0]       m_shift [RT_STAGES+1];
    logic [1:0]               m_mode  [RT_STAGES+1];
    logic signed [PROD_W-1:0] m_pa    [RT_STAGES+1][LANES];
    logic signed [PROD_W-1:0] m_pb    [RT_STAGES+1][LANES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= RT_STAGES; k++) begin
                m_vld[k] <= 1'b0; m_last[k] <= 1'b0; m_addr[k] <= '0;
                m_shift[k] <= '0; m_mode[k] <= '0;
                for (int i = 0; i < LANES; i++) begin
                    m_pa[k][i] <= '0;
                    m_pb[k][i] <= '0;
                end
            end
        end else if (adv) begin
            m_vld[0] <= s0_vld; m_last[0] <= s0_last; m_addr[0] <= s0_addr;
            m_shift[0] <= s0_shift; m_mode[0] <= s0_mode;
            for (int i = 0; i < LANES; i++) begin
                m_pa[0][i] <= prod_a[i];
                m_pb[0][i] <= prod_b[i];
            end
            for (int k = 1; k <= RT_STAGES; k++) begin
                m_vld[k] <= m_vld[k-1]; m_last[k] <= m_last[k-1]; m_addr[k] <= m_addr[k-1];
                m_shift[k] <= m_shift[k-1]; m_mode[k] <= m_mode[k-1];
                for (int i = 0; i < LANES; i++) begin
                    m_pa[k][i] <= m_pa[k-1][i];
                    m_pb[k][i] <= m_pb[k-1][i];
                end
            end
        end
    end

    logic signed [SUM_W-1:0] sum_next [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            case (m_mode[T])
                2'b01:   sum_next[i] = SUM_W'(m_pa[T][i]) - SUM_W'(m_pb[T][i]);
                2'b10:   sum_next[i] = SUM_W'(m_pa[T][i]);
                default: sum_next[i] = SUM_W'(m_pa[T][i]) + SUM_W'(m_pb[T][i]);
            endcase
        end
    end

    logic                    sa_vld, sa_last;
    logic [ADDR_W-1:0]       sa_addr;
    logic [SHIFT_W-1:0]      sa_shift;
    logic signed [SUM_W-1:0] sa_sum [LANES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_vld <= 1'b0; sa_last <= 1'b0; sa_addr <= '0; sa_shift <= '0;
            for (int i = 0; i < LANES; i++) sa_sum[i] <= '0;
        end else if (adv) begin
            sa_vld <= m_vld[T]; sa_last <= m_last[T]; sa_addr <= m_addr[T]; sa_shift <= m_shift[T];
            for (int i = 0; i < LANES; i++) sa_sum[i] <= sum_next[i];
        end
    end

    // Shifts beyond the sum width collapse to the sign; the round bit is the last bit shifted out
    logic [SHIFT_W-1:0]      eff_shift;
    logic signed [SUM_W-1:0] shr_next [LANES];
    logic signed [SUM_W-1:0] half     [LANES];
    logic                    rnd_next [LANES];

    always_comb begin
        eff_shift = sa_shift;
        if (int'(sa_shift) > SUM_W - 1) eff_shift = SHIFT_W'(SUM_W - 1);
        for (int i = 0; i < LANES; i++) begin
            shr_next[i] = sa_sum[i] >>> eff_shift;
            half[i]     = sa_sum[i] >>> (eff_shift - SHIFT_W'(1));
            rnd_next[i] = (eff_shift != '0) & half[i][0];
        end
    end

    logic                    ss_vld, ss_last;
    logic [ADDR_W-1:0]       ss_addr;
    logic signed [SUM_W-1:0] ss_val [LANES];
    logic                    ss_rnd [LANES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_vld <= 1'b0; ss_last <= 1'b0; ss_addr <= '0;
            for (int i = 0; i < LANES; i++) begin
                ss_val[i] <= '0;
                ss_rnd[i] <= 1'b0;
            end
        end else if (adv) begin
            ss_vld <= sa_vld; ss_last <= sa_last; ss_addr <= sa_addr;
            for (int i = 0; i < LANES; i++) begin
                ss_val[i] <= shr_next[i];
                ss_rnd[i] <= rnd_next[i];
            end
        end
    end

    logic signed [SUM_W-1:0] rsum [LANES];
    logic [LANES*OUT_W-1:0]  sat_data;

    always_comb begin
        sat_data = '0;
        for (int i = 0; i < LANES; i++) begin
            rsum[i] = ss_val[i] + $signed({{(SUM_W-1){1'b0}}, ss_rnd[i]});
            if (rsum[i] > SAT_MAX)      sat_data[i*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
            else if (rsum[i] < SAT_MIN) sat_data[i*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
            else                        sat_data[i*OUT_W +: OUT_W] = rsum[i][OUT_W-1:0];
        end
    end

    // Output payload only loads with a real beat so it holds its last value while idle
    logic                   out_vld_q, out_last_q;
    logic [ADDR_W-1:0]      out_addr_q;
    logic [LANES*OUT_W-1:0] out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0; out_last_q <= 1'b0; out_addr_q <= '0; out_data_q <= '0;
        end else if (adv) begin
            out_vld_q <= ss_vld;
            if (ss_vld) begin
                out_last_q <= ss_last;
                out_addr_q <= ss_addr;
                out_data_q <= sat_data;
            end
        end
    end

    assign bus.out_vld  = out_vld_q;
    assign bus.out_last = out_last_q;
    assign bus.out_addr = out_addr_q;
    assign bus.out_data = out_data_q;

    always_comb begin
        busy = s0_vld | sa_vld | ss_vld | out_vld_q;
        for (int k = 0; k <= RT_STAGES; k++) busy = busy | m_vld[k];
    end

`ifdef RESADD_SAT_STAT_EN
    localparam int CNT_W = $clog2(LANES + 1);
    logic [CNT_W-1:0] clip_cnt_next, out_clip_q;
    logic [16:0]      sat_sum;

    always_comb begin
        clip_cnt_next = '0;
        for (int i = 0; i < LANES; i++)
            clip_cnt_next = clip_cnt_next + CNT_W'((rsum[i] > SAT_MAX) || (rsum[i] < SAT_MIN));
    end

    assign sat_sum = {1'b0, sat_cnt} + 17'(out_clip_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_clip_q <= '0;
            sat_cnt    <= '0;
        end else begin
            if (adv && ss_vld) out_clip_q <= clip_cnt_next;
            if (cfg_load) sat_cnt <= '0;
            else if (out_vld_q && bus.out_rdy) sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_residual_adder_pipe.sv
// Directed bench for residual_adder_pipe: vector table plus backpressure, config and reset sequences.
module tb_residual_adder_pipe;
    localparam int LANES = 16, IN_W = 8, OUT_W = 8, SCALE_W = 16, SHIFT_W = 5, ADDR_W = 12;
    localparam int RT_STAGES = 1;
    localparam int LAT = 5 + RT_STAGES;
    localparam int DW  = LANES * OUT_W;
    localparam int IW  = LANES * IN_W;

    logic               clk, rst_n;
    logic               cfg_vld, cfg_err, busy;
    logic [SCALE_W-1:0] cfg_scale_a, cfg_scale_b;
    logic [SHIFT_W-1:0] cfg_shift;
    logic [1:0]         cfg_mode;
`ifdef RESADD_SAT_STAT_EN
    logic [15:0]        sat_cnt;
`endif

    residual_adder_pipe_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

    residual_adder_pipe #(
        .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .SCALE_W(SCALE_W),
        .SHIFT_W(SHIFT_W), .ADDR_W(ADDR_W), .RT_STAGES(RT_STAGES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_vld(cfg_vld), .cfg_scale_a(cfg_scale_a),
        .cfg_scale_b(cfg_scale_b), .cfg_shift(cfg_shift), .cfg_mode(cfg_mode),
        .cfg_err(cfg_err), .bus(bus), .busy(busy)
`ifdef RESADD_SAT_STAT_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        int a0, b0, a1, b1;
        int sa, sb, sh, mode;
        int e0, e1, clip;
    } vec_t;

    vec_t vecs [8];
    int   checks = 0;
    int   errors = 0;

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack_out(input int e0, input int e1);
        logic [DW-1:0] v;
        v = '0;
        v[OUT_W-1:0]       = e0[OUT_W-1:0];
        v[2*OUT_W-1:OUT_W] = e1[OUT_W-1:0];
        return v;
    endfunction

    function automatic logic [IW-1:0] pack_in(input int x0, input int x1);
        logic [IW-1:0] v;
        v = '0;
        v[IN_W-1:0]      = x0[IN_W-1:0];
        v[2*IN_W-1:IN_W] = x1[IN_W-1:0];
        return v;
    endfunction

    task automatic cfg_write(input int sa, input int sb, input int sh, input int mode);
        @(negedge clk);
        cfg_vld = 1'b1;
        cfg_scale_a = SCALE_W'(sa);
        cfg_scale_b = SCALE_W'(sb);
        cfg_shift   = SHIFT_W'(sh);
        cfg_mode    = 2'(mode);
        @(negedge clk);
        cfg_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output(name, DW'(busy), DW'(0));
    endtask

    // One beat; returns at the negedge after the accepting edge
    task automatic apply_stimulus(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                  input int addr, input logic last);
        @(negedge clk);
        bus.in_vld = 1'b1; bus.in_a = a; bus.in_b = b;
        bus.in_addr = ADDR_W'(addr); bus.in_last = last;
        @(negedge clk);
        bus.in_vld = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 1;
        while (!bus.out_vld && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    int lat, sent, got, stalls, lasts;
    logic prev_stall, prev_last;
    logic [DW-1:0] prev_data;
    logic [ADDR_W-1:0] prev_addr;

    initial begin
        vecs[0] = '{10, 20, -5, -7, 256, 256, 8, 0, 30, -12, 0};
        vecs[1] = '{100, 100, -100, -100, 256, 256, 8, 0, 127, -128, 2};
        vecs[2] = '{-100, 100, 5, 7, 256, 256, 8, 1, -128, -2, 1};
        vecs[3] = '{-3, 99, 4, -100, 256, 256, 8, 2, -3, 4, 0};
        vecs[4] = '{1, 50, -1, 50, 3, 0, 1, 0, 2, -1, 0};
        vecs[5] = '{-128, -128, 127, 127, 65535, 65535, 31, 0, -1, 1, 0};
        vecs[6] = '{-128, 0, 0, 0, 3, 0, 31, 0, 0, 0, 0};
        vecs[7] = '{1, 2, -128, -128, 256, 256, 8, 3, 3, -128, 1};

        rst_n = 1'b0; cfg_vld = 1'b0; cfg_scale_a = '0; cfg_scale_b = '0; cfg_shift = '0; cfg_mode = '0;
        bus.in_vld = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_addr = '0; bus.in_last = 1'b0;
        bus.out_rdy = 1'b1;
        repeat (2) @(negedge clk);
        check_output("reset_out_vld", DW'(bus.out_vld), DW'(0));
        check_output("reset_busy", DW'(busy), DW'(0));
        check_output("reset_cfg_err", DW'(cfg_err), DW'(0));
        check_output("reset_out_data", bus.out_data, '0);
        check_output("reset_out_addr", DW'(bus.out_addr), DW'(0));
        check_output("reset_out_last", DW'(bus.out_last), DW'(0));
        check_output("reset_in_rdy", DW'(bus.in_rdy), DW'(1));
`ifdef RESADD_SAT_STAT_EN
        check_output("reset_sat_cnt", DW'(sat_cnt), DW'(0));
`endif
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            cfg_write(vecs[v].sa, vecs[v].sb, vecs[v].sh, vecs[v].mode);
            apply_stimulus(pack_in(vecs[v].a0, vecs[v].a1), pack_in(vecs[v].b0, vecs[v].b1), v, 1'b1);
            wait_out(lat);
            check_output($sformatf("vec%0d_latency", v), DW'(lat), DW'(LAT));
            check_output($sformatf("vec%0d_data", v), bus.out_data, pack_out(vecs[v].e0, vecs[v].e1));
            check_output($sformatf("vec%0d_addr", v), DW'(bus.out_addr), DW'(v));
            check_output($sformatf("vec%0d_last", v), DW'(bus.out_last), DW'(1));
            @(negedge clk);
            check_output($sformatf("vec%0d_single_beat", v), DW'(bus.out_vld), DW'(0));
`ifdef RESADD_SAT_STAT_EN
            check_output($sformatf("vec%0d_sat_cnt", v), DW'(sat_cnt), DW'(vecs[v].clip));
`endif
        end
        repeat (3) @(negedge clk);
        check_output("idle_data_hold", bus.out_data, pack_out(vecs[7].e0, vecs[7].e1));

        // Same-cycle config write and beat: beat keeps the old scales, no error
        cfg_write(256, 256, 8, 0);
        wait_idle("idle_before_samecycle");
        @(negedge clk);
        cfg_vld = 1'b1; cfg_scale_a = SCALE_W'(768);
        bus.in_vld = 1'b1; bus.in_a = pack_in(1, 0); bus.in_b = pack_in(1, 0);
        bus.in_addr = ADDR_W'(20); bus.in_last = 1'b1;
        @(negedge clk);
        cfg_vld = 1'b0; bus.in_vld = 1'b0;
        wait_out(lat);
        check_output("samecycle_old_cfg", bus.out_data, pack_out(2, 0));
        check_output("samecycle_no_err", DW'(cfg_err), DW'(0));
        apply_stimulus(pack_in(1, 0), pack_in(1, 0), 21, 1'b1);
        wait_out(lat);
        check_output("samecycle_new_cfg", bus.out_data, pack_out(4, 0));

        // Config write while busy is dropped and flags the error
        wait_idle("idle_before_busycfg");
        cfg_write(256, 256, 8, 0);
        apply_stimulus(pack_in(1, 0), pack_in(1, 0), 30, 1'b1);
        cfg_write(512, 256, 8, 0);
        check_output("busy_cfg_err", DW'(cfg_err), DW'(1));
        wait_out(lat);
        check_output("busy_cfg_old_scale", bus.out_data, pack_out(2, 0));
        wait_idle("idle_after_busycfg");
        cfg_write(512, 256, 8, 0);
        apply_stimulus(pack_in(1, 0), pack_in(1, 0), 31, 1'b1);
        wait_out(lat);
        check_output("idle_cfg_new_scale", bus.out_data, pack_out(3, 0));
        check_output("cfg_err_sticky", DW'(cfg_err), DW'(1));

        // Backpressure: 8-beat burst, output stalled 3 cycles on the beat with addr 2
        wait_idle("idle_before_stream");
        cfg_write(256, 256, 8, 0);
        sent = 0; got = 0; stalls = 0; lasts = 0; prev_stall = 1'b0;
        prev_data = '0; prev_addr = '0; prev_last = 1'b0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            @(negedge clk);
            if (bus.out_vld && bus.out_addr == ADDR_W'(2) && stalls < 3) begin
                bus.out_rdy = 1'b0;
                stalls++;
            end else begin
                bus.out_rdy = 1'b1;
            end
            if (prev_stall) begin
                check_output("stall_hold_vld", DW'(bus.out_vld), DW'(1));
                check_output("stall_hold_data", bus.out_data, prev_data);
                check_output("stall_hold_addr", DW'(bus.out_addr), DW'(prev_addr));
                check_output("stall_hold_last", DW'(bus.out_last), DW'(prev_last));
            end
            if (bus.out_vld && bus.out_rdy) begin
                check_output($sformatf("stream%0d_addr", got), DW'(bus.out_addr), DW'(got));
                check_output($sformatf("stream%0d_data", got), bus.out_data, pack_out(3 * got, 0));
                check_output($sformatf("stream%0d_last", got), DW'(bus.out_last), DW'(got == 7));
                if (bus.out_last) lasts++;
                got++;
            end
            prev_stall = bus.out_vld && !bus.out_rdy;
            prev_data = bus.out_data; prev_addr = bus.out_addr; prev_last = bus.out_last;
            if (sent < 8) begin
                bus.in_vld = 1'b1; bus.in_a = pack_in(sent, 0); bus.in_b = pack_in(2 * sent, 0);
                bus.in_addr = ADDR_W'(sent); bus.in_last = (sent == 7);
            end else begin
                bus.in_vld = 1'b0;
            end
            #1;
            if (bus.in_vld && bus.in_rdy) sent++;
        end
        @(negedge clk);
        bus.in_vld = 1'b0; bus.out_rdy = 1'b1;
        check_output("stream_count", DW'(got), DW'(8));
        check_output("stream_last_count", DW'(lasts), DW'(1));
        check_output("stream_stall_cycles", DW'(stalls), DW'(3));

        // Reset with four beats in flight
        wait_idle("idle_before_reset");
        cfg_write(256, 256, 8, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_vld = 1'b1; bus.in_a = pack_in(k + 1, 0); bus.in_b = pack_in(k + 1, 0);
            bus.in_addr = ADDR_W'(40 + k); bus.in_last = (k == 3);
        end
        @(negedge clk);
        bus.in_vld = 1'b0;
        check_output("busy_before_reset", DW'(busy), DW'(1));
        rst_n = 1'b0;
        #1;
        check_output("reset_flush_out_vld", DW'(bus.out_vld), DW'(0));
        check_output("reset_flush_busy", DW'(busy), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        check_output("reset_clears_cfg_err", DW'(cfg_err), DW'(0));
        cfg_write(256, 256, 8, 0);
        apply_stimulus(pack_in(10, 0), pack_in(20, 0), 50, 1'b1);
        wait_out(lat);
        check_output("post_reset_latency", DW'(lat), DW'(LAT));
        check_output("post_reset_data", bus.out_data, pack_out(30, 0));
        check_output("post_reset_addr", DW'(bus.out_addr), DW'(50));
        @(negedge clk);
        check_output("post_reset_no_stale", DW'(bus.out_vld), DW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
